// File: rtl/scan_pkg.sv
// Shared types and default addresses for the pattern-count sequencer.
// Message layout: byte 0 is the most-significant byte of the scanned bit string.
package scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_PAT = 3'd1,
    ST_SCAN   = 3'd2,
    ST_WR_CTB = 3'd3,
    ST_WR_CTO = 3'd4,
    ST_WR_CTS = 3'd5,
    ST_DONE   = 3'd6
  } scan_state_t;

  localparam int DEF_MSG_BASE = 0;
  localparam int DEF_MSG_LEN  = 32;
  localparam int DEF_PAT_ADDR = 32;
  localparam int DEF_RES_ADDR = 67;

endpackage

// File: rtl/pat_window_cnt.sv
// Counts 5-bit pattern hits in one message byte, plus the windows that straddle the previous byte.
// Latency: purely combinational. Backpressure: none, the caller presents one byte per cycle.
// Crossing hits are suppressed on the first byte because no previous byte exists yet.
module pat_window_cnt (
  input  logic [4:0] pat,
  input  logic [3:0] prev,
  input  logic [7:0] cur,
  input  logic       first,
  output logic [2:0] in_cnt,
  output logic       any_in,
  output logic [2:0] x_cnt
);

  logic [11:0] joined;
  logic [3:0]  in_hit;
  logic [3:0]  x_hit;

  assign joined = {prev, cur};

  assign in_hit[0] = (cur[7:3] == pat);
  assign in_hit[1] = (cur[6:2] == pat);
  assign in_hit[2] = (cur[5:1] == pat);
  assign in_hit[3] = (cur[4:0] == pat);

  assign x_hit[0] = (joined[11:7] == pat);
  assign x_hit[1] = (joined[10:6] == pat);
  assign x_hit[2] = (joined[9:5]  == pat);
  assign x_hit[3] = (joined[8:4]  == pat);

  assign in_cnt = {2'b00, in_hit[0]} + {2'b00, in_hit[1]}
                + {2'b00, in_hit[2]} + {2'b00, in_hit[3]};
  assign any_in = |in_hit;
  assign x_cnt  = first ? 3'd0
                        : ({2'b00, x_hit[0]} + {2'b00, x_hit[1]}
                         + {2'b00, x_hit[2]} + {2'b00, x_hit[3]});

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Sequencer that owns the data-memory port while counting pattern hits and writing three results.
// Latency: 36 cycles from accepted start to done. Backpressure: start is ignored while busy.
// The memory port is decoded from the state register, so the address is valid in the same cycle as rdata.
module pattern_scan_ctrl
  import scan_pkg::*;
#(
  parameter int MSG_BASE = DEF_MSG_BASE,
  parameter int MSG_LEN  = DEF_MSG_LEN,
  parameter int PAT_ADDR = DEF_PAT_ADDR,
  parameter int RES_ADDR = DEF_RES_ADDR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic       busy,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic       mem_we,
  output logic [7:0] mem_wdata
);

  localparam logic [7:0] MSG_BASE_B = 8'(MSG_BASE);
  localparam logic [7:0] PAT_ADDR_B = 8'(PAT_ADDR);
  localparam logic [7:0] RES_ADDR_B = 8'(RES_ADDR);
  localparam logic [7:0] LAST_IDX   = 8'(MSG_LEN - 1);

  scan_state_t state;
  logic [4:0]  pat;
  logic [3:0]  prev;
  logic [7:0]  idx;
  logic [7:0]  ctb;
  logic [7:0]  cto;
  logic [7:0]  cts;
  logic [2:0]  in_cnt;
  logic [2:0]  x_cnt;
  logic        any_in;

  pat_window_cnt u_win (
    .pat    (pat),
    .prev   (prev),
    .cur    (mem_rdata),
    .first  (idx == 8'd0),
    .in_cnt (in_cnt),
    .any_in (any_in),
    .x_cnt  (x_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      pat   <= '0;
      prev  <= '0;
      idx   <= '0;
      ctb   <= '0;
      cto   <= '0;
      cts   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_RD_PAT;
            idx   <= '0;
            ctb   <= '0;
            cto   <= '0;
            cts   <= '0;
          end
        end
        ST_RD_PAT: begin
          pat   <= mem_rdata[7:3];
          state <= ST_SCAN;
        end
        ST_SCAN: begin
          ctb  <= ctb + {5'd0, in_cnt};
          cto  <= cto + {7'd0, any_in};
          cts  <= cts + {5'd0, in_cnt} + {5'd0, x_cnt};
          prev <= mem_rdata[3:0];
          if (idx == LAST_IDX) begin
            state <= ST_WR_CTB;
          end else begin
            idx <= idx + 8'd1;
          end
        end
        ST_WR_CTB: state <= ST_WR_CTO;
        ST_WR_CTO: state <= ST_WR_CTS;
        ST_WR_CTS: state <= ST_DONE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Idle and done leave the port at all-zero so the top-level mux sees a quiet bus.
  always_comb begin
    mem_addr  = 8'd0;
    mem_we    = 1'b0;
    mem_wdata = 8'd0;
    case (state)
      ST_RD_PAT: mem_addr = PAT_ADDR_B;
      ST_SCAN:   mem_addr = MSG_BASE_B + idx;
      ST_WR_CTB: begin
        mem_addr  = RES_ADDR_B;
        mem_we    = 1'b1;
        mem_wdata = ctb;
      end
      ST_WR_CTO: begin
        mem_addr  = RES_ADDR_B + 8'd1;
        mem_we    = 1'b1;
        mem_wdata = cto;
      end
      ST_WR_CTS: begin
        mem_addr  = RES_ADDR_B + 8'd2;
        mem_we    = 1'b1;
        mem_wdata = cts;
      end
      default: ;
    endcase
  end

  assign busy = (state != ST_IDLE) && (state != ST_DONE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: behavioural memory, bit-string reference model, directed and random jobs.
module tb_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic       busy;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_we;
  logic [7:0] mem_wdata;

  logic [7:0] mem [256];
  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;

  always #5 clk = ~clk;

  pattern_scan_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Each write must land on the next result address in order.
  always @(negedge clk) begin
    if (mem_we) begin
      chk("wr_addr", int'(mem_addr), 67 + wr_cnt);
      wr_cnt++;
    end
  end

  // Treat the message as one 256-bit string and slide a 5-bit window over every position.
  task automatic model(input logic [4:0] pat, output int ctb, output int cto, output int cts);
    logic [255:0] bits;
    bit hit_in_byte [32];
    for (int b = 0; b < 32; b++) begin
      bits[255 - 8*b -: 8] = mem[b];
      hit_in_byte[b] = 1'b0;
    end
    ctb = 0; cto = 0; cts = 0;
    for (int p = 0; p <= 251; p++) begin
      if (bits[255 - p -: 5] == pat) begin
        cts++;
        if ((p % 8) <= 3) begin
          ctb++;
          hit_in_byte[p / 8] = 1'b1;
        end
      end
    end
    for (int b = 0; b < 32; b++) cto += int'(hit_in_byte[b]);
  endtask

  task automatic load(input logic [4:0] pat, input logic [7:0] fill);
    for (int b = 0; b < 32; b++) mem[b] = fill;
    mem[32] = {pat, 3'($urandom_range(0, 7))};
  endtask

  // Runs one job; restart_at re-pulses start before that edge, rst_at pulses reset before that edge.
  task automatic run_job(input string tag, input int restart_at, input int rst_at,
                         input int e_ctb, input int e_cto, input int e_cts);
    int  n;
    bit  got;
    wr_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_done_clr"}, int'(done), 0);
    chk({tag, "_busy_go"}, int'(busy), 1);
    n = 0;
    got = 1'b0;
    while (n < 80 && !got) begin
      if (n + 1 == restart_at) start = 1'b1;
      if (n + 1 == rst_at) reset = 1'b1;
      @(posedge clk);
      n++;
      #1;
      start = 1'b0;
      if (n == rst_at) begin
        reset = 1'b0;
        chk({tag, "_rst_busy"}, int'(busy), 0);
        chk({tag, "_rst_we"}, int'(mem_we), 0);
        chk({tag, "_rst_done"}, int'(done), 0);
        chk({tag, "_rst_addr"}, int'(mem_addr), 0);
        return;
      end
      if (done) got = 1'b1;
    end
    chk({tag, "_latency"}, n, 36);
    chk({tag, "_nwr"}, wr_cnt, 3);
    chk({tag, "_ctb"}, int'(mem[67]), e_ctb);
    chk({tag, "_cto"}, int'(mem[68]), e_cto);
    chk({tag, "_cts"}, int'(mem[69]), e_cts);
    @(posedge clk);
    #1;
    chk({tag, "_done_hold"}, int'(done), 1);
  endtask

  initial begin
    int mb, mo, ms;
    logic [4:0] rp;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    reset = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_wdata", int'(mem_wdata), 0);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);

    load(5'b00000, 8'h00);
    run_job("zeros", 0, 0, 128, 32, 252);

    load(5'b10101, 8'h55);
    run_job("alt55", 0, 0, 64, 32, 126);

    load(5'b11111, 8'h00);
    mem[0] = 8'h0F;
    mem[1] = 8'h80;
    run_job("cross", 0, 0, 0, 0, 1);

    load(5'b11111, 8'h00);
    mem[67] = 8'hEE; mem[68] = 8'hEE; mem[69] = 8'hEE;
    run_job("nohit", 0, 0, 0, 0, 0);

    load(5'b10110, 8'h00);
    mem[67] = 8'hA5; mem[68] = 8'hA5; mem[69] = 8'hA5;
    run_job("rstmid", 0, 10, 0, 0, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("rstmid_m67", int'(mem[67]), 8'hA5);
    chk("rstmid_m68", int'(mem[68]), 8'hA5);
    chk("rstmid_m69", int'(mem[69]), 8'hA5);
    chk("rstmid_idle", int'(busy), 0);

    for (int b = 0; b < 32; b++) mem[b] = 8'($urandom);
    model(mem[32][7:3], mb, mo, ms);
    run_job("fresh", 0, 0, mb, mo, ms);

    run_job("restart", 15, 0, mb, mo, ms);
    run_job("rerun", 0, 0, mb, mo, ms);

    for (int t = 0; t < 8; t++) begin
      rp = 5'($urandom);
      for (int b = 0; b < 32; b++) begin
        // Bias some bytes toward the pattern so hits actually occur.
        if ($urandom_range(0, 2) == 0) mem[b] = {rp, 3'($urandom)};
        else mem[b] = 8'($urandom);
      end
      mem[32] = {rp, 3'($urandom)};
      model(rp, mb, mo, ms);
      run_job($sformatf("rand%0d", t), 0, 0, mb, mo, ms);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Hardware sequencer that takes over the data-memory port and runs the program-3 pattern-count job without the core. On `start` it reads the 5-bit pattern from the pattern byte and scans the 32-byte message. It then writes the three result counts back to data memory and raises `done`. It sits beside the core in `top_level`; its `busy` output steers the data-memory address and write muxes away from the core.

## Interface
Parameters:
- `MSG_BASE`, 0: address of message byte 0 (most-significant byte of the string).
- `MSG_LEN`, 32: number of message bytes.
- `PAT_ADDR`, 32: pattern byte address; pattern = byte[7:3].
- `RES_ADDR`, 67: base result address; writes RES_ADDR+0/+1/+2.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; sampled in IDLE or DONE.
- `done`  out  1  job complete; level, held until next accepted start or reset.
- `busy`  out  1  owns the data-memory port (top level muxes address/we/wdata).
- `mem_addr`  out  8  data-memory address.
- `mem_rdata`  in  8  data-memory read data, combinational (same cycle as `mem_addr`).
- `mem_we`  out  1  write enable; write commits at the rising edge.
- `mem_wdata`  out  8  write data.

## Operation
- Reset values:
  - `done`=0, `busy`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - State IDLE; all counters and registers cleared.
- State sequence: IDLE → RD_PAT → SCAN → WR_CTB → WR_CTO → WR_CTS → DONE.
- IDLE/DONE: `busy`=0. A `start` seen here moves to RD_PAT and clears `done`, byte index `i`, and all counts.
- RD_PAT: `mem_addr`=PAT_ADDR; latch `pat`=rdata[7:3].
- SCAN, one byte per cycle, `mem_addr`=MSG_BASE+i, `cur`=rdata:
  - In-byte windows: `cur`[7:3], [6:2], [5:1], [4:0].
    - `ctb` += number of these windows equal to `pat`.
    - `cto` += 1 if any of them matches.
  - Crossing windows (only when i>0): taken from the 12-bit `{prev[3:0],cur}` at bit slices [11:7], [10:6], [9:5], [8:4].
  - `cts` += in-byte matches + crossing matches.
  - `prev` ← `cur`; leave SCAN after i = MSG_LEN−1.
  - Byte 0 contributes 4 windows and bytes 1..31 contribute 8 each, giving 252 windows total.
- Write states (one cycle each, `mem_we`=1):
  - WR_CTB: RES_ADDR ← `ctb`.
  - WR_CTO: RES_ADDR+1 ← `cto`.
  - WR_CTS: RES_ADDR+2 ← `cts`.
- Counters are 8 bits with no saturation. Maximums: `ctb` 128, `cto` 32, `cts` 252, so none overflows.
- `busy`=1 in RD_PAT, SCAN and the write states only.

## Timing
- Take the start edge as edge 0.
- Edge 1: enter SCAN.
- Edges 2..33: accumulate bytes 0..31.
- Edges 34, 35, 36: commit the ctb, cto and cts writes.
- Edge 36: `done`=1.
- Total: 36 cycles from start to `done`.
- `start` while busy: ignored, with no restart and no queueing.
- `start` in DONE: accepted. `done` falls at the next edge and the job reruns.
- `reset` mid-job:
  - Next edge forces IDLE with all outputs at their reset values.
  - Writes already committed stay in memory; no further writes occur.
- `reset` and `start` in the same cycle: reset wins.
- `mem_we` is never high outside the three write states.

## Structure
- Package `scan_pkg`:
  - State enum `scan_state_t`.
  - Defaults for address constants `MSG_BASE`, `PAT_ADDR`, `RES_ADDR`.
  - `MSG_LEN`.
- Sub-module `pat_window_cnt` (combinational):
  - Inputs: `pat[4:0]`, `prev[3:0]`, `cur[7:0]`, `first`.
  - Outputs: `in_cnt[2:0]`, `any_in`, `x_cnt[2:0]`.
  - `x_cnt` is forced to 0 when `first`=1.
- The top FSM holds the state, index, counters and memory-port muxing.

## Test plan
- `pat`=00000, all bytes 0x00 → ctb=128, cto=32, cts=252; `done` at edge 36.
- `pat`=10101, all bytes 0x55 → ctb=64, cto=32, cts=126.
- `pat`=11111, byte0=0x0F, byte1=0x80, rest 0x00 → ctb=0, cto=0, cts=1 (crossing only).
- `pat`=11111, all bytes 0x00 → 0, 0, 0; all three writes still occur at addresses 67/68/69.
- `reset` pulsed at edge 10 of a job:
  - `busy`, `mem_we` and `done` are 0 from the next edge, and addresses 67–69 are unchanged.
  - A fresh `start` then yields correct counts.
- `start` re-pulsed during SCAN is ignored (same 36-cycle latency). A `start` in DONE drops `done` and reruns with identical results.
